// File: rtl/age_issue_queue.sv
// Age-ordered issue queue: entries wait on CDB wakeups and issue oldest-ready first
// (or strictly oldest-first when IN_ORDER=1). Age is tracked with a pairwise matrix.
module age_issue_queue #(
  parameter int DEPTH         = 8,
  parameter int NUM_CDB       = 4,
  parameter int ROB_IDX_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int OP_WIDTH      = 8,
  parameter int IN_ORDER      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; alloc_ready and issue_valid/payload depend on registered state only.
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [OP_WIDTH-1:0]      alloc_op,
  input  logic [ROB_IDX_WIDTH-1:0] alloc_rd_tag,
  input  logic                     alloc_rs1_ready,
  input  logic [ROB_IDX_WIDTH-1:0] alloc_rs1_tag,
  input  logic [DATA_WIDTH-1:0]    alloc_rs1_data,
  input  logic                     alloc_rs2_ready,
  input  logic [ROB_IDX_WIDTH-1:0] alloc_rs2_tag,
  input  logic [DATA_WIDTH-1:0]    alloc_rs2_data,
  input  logic                     cdb_valid [NUM_CDB],
  input  logic [ROB_IDX_WIDTH-1:0] cdb_tag   [NUM_CDB],
  input  logic [DATA_WIDTH-1:0]    cdb_data  [NUM_CDB],
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [OP_WIDTH-1:0]      issue_op,
  output logic [ROB_IDX_WIDTH-1:0] issue_rd_tag,
  output logic [DATA_WIDTH-1:0]    issue_rs1_data,
  output logic [DATA_WIDTH-1:0]    issue_rs2_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [OP_WIDTH-1:0]      op;
    logic [ROB_IDX_WIDTH-1:0] rd_tag;
    logic                     rs1_rdy;
    logic [ROB_IDX_WIDTH-1:0] rs1_tag;
    logic [DATA_WIDTH-1:0]    rs1_data;
    logic                     rs2_rdy;
    logic [ROB_IDX_WIDTH-1:0] rs2_tag;
    logic [DATA_WIDTH-1:0]    rs2_data;
  } entry_t;

  entry_t           ent_q   [DEPTH];
  entry_t           ent_d   [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  // older_q[i][j] set means entry i was allocated before entry j.
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;

  logic [DEPTH-1:0] elig;
  logic [DEPTH-1:0] oldest_elig_oh;
  logic [DEPTH-1:0] oldest_valid_oh;
  logic [DEPTH-1:0] sel_oh;
  logic [DEPTH-1:0] col;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] free_idx;
  logic             alloc_fire;
  logic             issue_fire;
  entry_t           alloc_ent;

  // Descending scan so the lowest-index matching CDB port wins.
  function automatic entry_t wake(input entry_t e);
    entry_t r;
    r = e;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (!e.rs1_rdy && cdb_valid[k] && (cdb_tag[k] == e.rs1_tag)) begin
        r.rs1_rdy  = 1'b1;
        r.rs1_data = cdb_data[k];
      end
      if (!e.rs2_rdy && cdb_valid[k] && (cdb_tag[k] == e.rs2_tag)) begin
        r.rs2_rdy  = 1'b1;
        r.rs2_data = cdb_data[k];
      end
    end
    return r;
  endfunction

  always_comb begin
    elig            = '0;
    oldest_elig_oh  = '0;
    oldest_valid_oh = '0;
    col             = '0;
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = valid_q[i] && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy;
    end
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        col[j] = older_q[j][i];
      end
      oldest_elig_oh[i]  = elig[i] && ((elig & col) == '0);
      oldest_valid_oh[i] = valid_q[i] && ((valid_q & col) == '0);
    end
    if (IN_ORDER != 0) begin
      sel_oh = oldest_valid_oh & elig;
    end else begin
      sel_oh = oldest_elig_oh;
    end
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_oh[i]) sel_idx = IDX_W'(i);
    end
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  assign alloc_ready = (count_q < DEPTH_C);
  assign issue_valid = |sel_oh;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign issue_fire  = issue_valid && issue_ready;
  assign count       = count_q;

  assign issue_op       = issue_valid ? ent_q[sel_idx].op       : '0;
  assign issue_rd_tag   = issue_valid ? ent_q[sel_idx].rd_tag   : '0;
  assign issue_rs1_data = issue_valid ? ent_q[sel_idx].rs1_data : '0;
  assign issue_rs2_data = issue_valid ? ent_q[sel_idx].rs2_data : '0;

  always_comb begin
    alloc_ent.op       = alloc_op;
    alloc_ent.rd_tag   = alloc_rd_tag;
    alloc_ent.rs1_rdy  = alloc_rs1_ready;
    alloc_ent.rs1_tag  = alloc_rs1_tag;
    alloc_ent.rs1_data = alloc_rs1_data;
    alloc_ent.rs2_rdy  = alloc_rs2_ready;
    alloc_ent.rs2_tag  = alloc_rs2_tag;
    alloc_ent.rs2_data = alloc_rs2_data;
  end

  always_comb begin
    valid_d = valid_q;
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i]   = wake(ent_q[i]);
      older_d[i] = older_q[i];
    end
    if (issue_fire) valid_d[sel_idx] = 1'b0;
    // The free slot is never the issuing slot, so both updates can coexist.
    if (alloc_fire) begin
      ent_d[free_idx]   = wake(alloc_ent);
      valid_d[free_idx] = 1'b1;
      for (int j = 0; j < DEPTH; j++) begin
        older_d[j][free_idx] = 1'b1;
      end
      older_d[free_idx] = '0;
    end
    case ({alloc_fire, issue_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
    for (int i = 0; i < DEPTH; i++) begin
      ent_q[i]   <= ent_d[i];
      older_q[i] <= older_d[i];
    end
  end

endmodule
